// File: rtl/sn74163_if.sv
// Pin bundle for the SN74163 4-bit synchronous counter: data, enables, load,
// supply pins and outputs. Clock (P2) and clear (P1) stay plain module ports.
interface sn74163_if;
    logic P3;   // A (LSB)
    logic P4;   // B
    logic P5;   // C
    logic P6;   // D (MSB)
    logic P7;   // ENP
    logic P8;   // GND
    logic P9;   // LOAD_n
    logic P10;  // ENT
    logic P11;  // QD
    logic P12;  // QC
    logic P13;  // QB
    logic P14;  // QA
    logic P15;  // RCO
    logic P16;  // VCC

    modport master (
        output P3, P4, P5, P6, P7, P8, P9, P10, P16,
        input  P11, P12, P13, P14, P15
    );

    modport slave (
        input  P3, P4, P5, P6, P7, P8, P9, P10, P16,
        output P11, P12, P13, P14, P15
    );
endinterface

// File: rtl/sn74163.sv
// SN74163 synchronous 4-bit binary counter with synchronous clear and load.
// Optional macro SN74163_POWER_CHECK_EN gates state updates on P16=1, P8=0.
module sn74163 (
    input logic        P2,   // CLK
    input logic        P1,   // CLR_n
    sn74163_if.slave   pins
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       rco_comb;

    always_comb begin
        cnt_d = cnt_q;
        if (!pins.P9) begin
            cnt_d = {pins.P6, pins.P5, pins.P4, pins.P3};
        end else if (pins.P7 && pins.P10) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign rco_comb = pins.P10 & (&cnt_q);

`ifdef SN74163_POWER_CHECK_EN
    logic power_ok;
    logic rco_q;

    assign power_ok = pins.P16 & ~pins.P8;

    always_ff @(posedge P2) begin
        if (power_ok) begin
            if (!P1) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Remember the last RCO seen while powered so it can be frozen on supply loss.
    always_ff @(posedge P2) begin
        if (power_ok) begin
            rco_q <= rco_comb;
        end
    end

    assign pins.P15 = power_ok ? rco_comb : rco_q;
`else
    logic unused_supply;

    assign unused_supply = pins.P8 ^ pins.P16;

    always_ff @(posedge P2) begin
        if (!P1) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pins.P15 = rco_comb;
`endif

    assign pins.P14 = cnt_q[0];
    assign pins.P13 = cnt_q[1];
    assign pins.P12 = cnt_q[2];
    assign pins.P11 = cnt_q[3];

endmodule

// File: tb/tb_sn74163.sv
// Self-checking bench for sn74163: directed scenarios plus randomized
// stimulus compared against an arithmetic reference model.
module tb_sn74163;

    logic clk;
    logic clr_n;
    int   tests_run;
    int   tests_failed;
    int   model_q;

    sn74163_if pins ();

    sn74163 dut (
        .P2   (clk),
        .P1   (clr_n),
        .pins (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dut_q();
        return {28'd0, pins.P11, pins.P12, pins.P13, pins.P14};
    endfunction

    function automatic int model_rco();
        return (pins.P10 && model_q == 15) ? 1 : 0;
    endfunction

    task automatic drive(input logic clr, input logic ld, input int data,
                         input logic enp, input logic ent);
        logic [3:0] d4;
        d4       = data[3:0];
        clr_n    = clr;
        pins.P9  = ld;
        pins.P3  = d4[0];
        pins.P4  = d4[1];
        pins.P5  = d4[2];
        pins.P6  = d4[3];
        pins.P7  = enp;
        pins.P10 = ent;
    endtask

    // Advance one rising edge, update the model from the pin rules, check outputs.
    task automatic step(input string tag, input bit powered);
        int data;
        @(posedge clk);
        data = 8 * pins.P6 + 4 * pins.P5 + 2 * pins.P4 + pins.P3;
        if (powered) begin
            if (!clr_n)                  model_q = 0;
            else if (!pins.P9)           model_q = data;
            else if (pins.P7 && pins.P10) model_q = (model_q + 1) % 16;
        end
        #1;
        check({tag, "_q"}, dut_q(), model_q);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_q      = 0;
        pins.P8      = 1'b0;
        pins.P16     = 1'b1;
        drive(1'b1, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset state
        drive(1'b0, 1'b0, 9, 1'b1, 1'b1);
        step("reset", 1'b1);
        check("reset_rco", int'(pins.P15), 0);

        // Full count sequence with wrap
        drive(1'b1, 1'b1, 0, 1'b1, 1'b1);
        #1;
        check("seq_rco0", int'(pins.P15), 0);
        for (int i = 1; i <= 16; i++) begin
            step("seq", 1'b1);
            check("seq_val", dut_q(), i % 16);
            check("seq_rco", int'(pins.P15), (i == 15) ? 1 : 0);
        end

        // Clear beats load on the same edge, then load takes effect
        drive(1'b1, 1'b0, 5, 1'b0, 1'b0);
        step("ld5", 1'b1);
        drive(1'b0, 1'b0, 10, 1'b1, 1'b1);
        step("clrwin", 1'b1);
        check("clrwin_val", dut_q(), 0);
        drive(1'b1, 1'b0, 10, 1'b1, 1'b1);
        step("ld10", 1'b1);
        check("ld10_val", dut_q(), 10);

        // Cascade hold at terminal count, RCO follows ENT without a clock
        drive(1'b1, 1'b0, 15, 1'b1, 1'b1);
        step("ld15", 1'b1);
        drive(1'b1, 1'b1, 0, 1'b0, 1'b1);
        step("hold15", 1'b1);
        check("hold15_val", dut_q(), 15);
        check("hold15_rco", int'(pins.P15), 1);
        pins.P10 = 1'b0;
        #1;
        check("ent_drop_rco", int'(pins.P15), 0);

        // CLR_n pulse between edges has no effect
        drive(1'b1, 1'b0, 3, 1'b0, 1'b0);
        step("ld3", 1'b1);
        drive(1'b1, 1'b1, 0, 1'b1, 1'b1);
        #1 clr_n = 1'b0;
        #1 clr_n = 1'b1;
        step("glitch", 1'b1);
        check("glitch_val", dut_q(), 4);

        // Supply-pin behaviour
        drive(1'b1, 1'b0, 6, 1'b1, 1'b1);
        step("ld6", 1'b1);
        drive(1'b1, 1'b1, 0, 1'b1, 1'b1);
        pins.P16 = 1'b0;
`ifdef SN74163_POWER_CHECK_EN
        for (int i = 0; i < 3; i++) step("nopwr", 1'b0);
        check("nopwr_val", dut_q(), 6);
        pins.P16 = 1'b1;
        pins.P8  = 1'b0;
        step("repwr", 1'b1);
        check("repwr_val", dut_q(), 7);
`else
        for (int i = 0; i < 3; i++) step("nopwr", 1'b1);
        check("nopwr_val", dut_q(), 9);
        pins.P16 = 1'b1;
        pins.P8  = 1'b0;
        step("repwr", 1'b1);
        check("repwr_val", dut_q(), 10);
`endif

        // Randomized operation against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(15) != 0), ($urandom_range(7) != 0),
                  int'($urandom_range(15)), 1'($urandom), 1'($urandom));
            #1;
            check("rnd_rco_pre", int'(pins.P15), model_rco());
            step("rnd", 1'b1);
            check("rnd_rco", int'(pins.P15), model_rco());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
